// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage:
// default reset PC, bubble encoding and FSM state encoding.
package fetch_stage_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_buffer.sv
// One-entry holding register for a fetched word
// and its PC+4 while decode is stalled.
module fetch_buffer (
   input  logic        Clk,
   input  logic        ResetN,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] pc4_i,
   output logic        valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc4_o
);

   logic        valid_q;
   logic [31:0] inst_q;
   logic [31:0] pc4_q;

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc4_q   <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         inst_q  <= inst_i;
         pc4_q   <= pc4_i;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign inst_o  = inst_q;
   assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single outstanding request,
// stall buffering and branch/jump redirect handling.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
   input  logic        Clk,
   input  logic        ResetN,
   input  logic        Stall,
   input  logic        Branch,
   input  logic        Jump,
   input  logic [31:0] BranchOffset,
   input  logic [25:0] JumpAddress,
   input  logic        IMemReady,
   input  logic [31:0] IMemData,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   output logic [31:0] Inst,
   output logic        InstValid,
   output logic [31:0] IDPCPlus4
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tgt_q, tgt_d;
   logic [31:0]  inst_q, inst_d;
   logic         valid_q, valid_d;
   logic [31:0]  idpc4_q, idpc4_d;
   logic         run_q;

   logic        buf_load, buf_clear, buf_valid;
   logic [31:0] buf_inst, buf_pc4;

   logic [31:0] pc_plus4;
   logic [31:0] jmp_tgt;
   logic [31:0] br_tgt;
   logic        redirect;
   logic [31:0] red_tgt;

   assign pc_plus4 = pc_q + 32'd4;
   assign jmp_tgt  = {idpc4_q[31:28], JumpAddress, 2'b00};
   assign br_tgt   = idpc4_q + (BranchOffset << 2);
   assign redirect = Jump | (Branch & ~Stall);
   assign red_tgt  = Jump ? jmp_tgt : br_tgt;

   fetch_buffer u_buf (
      .Clk     (Clk),
      .ResetN  (ResetN),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .inst_i  (IMemData),
      .pc4_i   (pc_plus4),
      .valid_o (buf_valid),
      .inst_o  (buf_inst),
      .pc4_o   (buf_pc4)
   );

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
         idpc4_q <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         idpc4_q <= idpc4_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      inst_d    = inst_q;
      valid_d   = valid_q;
      idpc4_d   = idpc4_q;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (redirect) begin
               inst_d    = NOP_INST;
               valid_d   = 1'b0;
               buf_clear = 1'b1;
               // the old request is still in flight: drain it first
               if (run_q && !IMemReady) begin
                  tgt_d   = red_tgt;
                  state_d = DROP;
               end else begin
                  pc_d = red_tgt;
               end
            end else if (run_q && IMemReady) begin
               pc_d = pc_plus4;
               if (Stall) begin
                  buf_load = 1'b1;
                  state_d  = HOLD;
               end else begin
                  inst_d  = IMemData;
                  valid_d = 1'b1;
                  idpc4_d = pc_plus4;
               end
            end else if (!Stall) begin
               inst_d  = NOP_INST;
               valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d      = red_tgt;
               inst_d    = NOP_INST;
               valid_d   = 1'b0;
               buf_clear = 1'b1;
               state_d   = FETCH;
            end else if (!Stall) begin
               inst_d    = buf_inst;
               valid_d   = buf_valid;
               idpc4_d   = buf_pc4;
               buf_clear = 1'b1;
               state_d   = FETCH;
            end
         end
         DROP: begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            if (redirect) begin
               tgt_d = red_tgt;
            end
            if (IMemReady) begin
               pc_d    = redirect ? red_tgt : tgt_q;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   assign IMemReq   = run_q & (state_q != HOLD);
   assign IMemAddr  = pc_q;
   assign Inst      = inst_q;
   assign InstValid = valid_q;
   assign IDPCPlus4 = idpc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

   logic        Clk = 1'b0;
   logic        ResetN;
   logic        Stall;
   logic        Branch;
   logic        Jump;
   logic [31:0] BranchOffset;
   logic [25:0] JumpAddress;
   logic        IMemReady;
   logic [31:0] IMemData;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic [31:0] Inst;
   logic        InstValid;
   logic [31:0] IDPCPlus4;

   int nchecks = 0;
   int nerrors = 0;

   fetch_stage dut (
      .Clk          (Clk),
      .ResetN       (ResetN),
      .Stall        (Stall),
      .Branch       (Branch),
      .Jump         (Jump),
      .BranchOffset (BranchOffset),
      .JumpAddress  (JumpAddress),
      .IMemReady    (IMemReady),
      .IMemData     (IMemData),
      .IMemReq      (IMemReq),
      .IMemAddr     (IMemAddr),
      .Inst         (Inst),
      .InstValid    (InstValid),
      .IDPCPlus4    (IDPCPlus4)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic st, input logic br, input logic jp,
                       input logic [31:0] off, input logic [25:0] ja,
                       input logic rdy, input logic [31:0] data);
      Stall        = st;
      Branch       = br;
      Jump         = jp;
      BranchOffset = off;
      JumpAddress  = ja;
      IMemReady    = rdy;
      IMemData     = data;
      @(posedge Clk);
      #1;
   endtask

   task automatic seq(input logic rdy, input logic [31:0] data);
      step(1'b0, 1'b0, 1'b0, 32'd0, 26'd0, rdy, data);
   endtask

   initial begin
      ResetN = 1'b0;
      seq(1'b0, 32'd0);
      seq(1'b0, 32'd0);
      check("rst_req", {31'd0, IMemReq}, 32'd0);
      check("rst_addr", IMemAddr, 32'h0);
      check("rst_inst", Inst, 32'h0);
      check("rst_valid", {31'd0, InstValid}, 32'd0);
      check("rst_idpc4", IDPCPlus4, 32'h0);
      ResetN = 1'b1;
      #1;
      check("rel_req0", {31'd0, IMemReq}, 32'd0);
      seq(1'b0, 32'd0);
      check("rel_req1", {31'd0, IMemReq}, 32'd1);
      check("rel_addr", IMemAddr, 32'h0);

      // sequential fetch 0,4,8
      seq(1'b1, 32'h1111_0000);
      check("seq0_inst", Inst, 32'h1111_0000);
      check("seq0_valid", {31'd0, InstValid}, 32'd1);
      check("seq0_idpc4", IDPCPlus4, 32'h4);
      check("seq0_addr", IMemAddr, 32'h4);
      seq(1'b1, 32'h1111_0004);
      check("seq1_inst", Inst, 32'h1111_0004);
      check("seq1_addr", IMemAddr, 32'h8);

      // stall three cycles while 0x20020005 returns at 8
      step(1'b1, 1'b0, 1'b0, 32'd0, 26'd0, 1'b1, 32'h2002_0005);
      check("hold_inst", Inst, 32'h1111_0004);
      check("hold_idpc4", IDPCPlus4, 32'h8);
      check("hold_req", {31'd0, IMemReq}, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 26'd0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 26'd0, 1'b0, 32'd0);
      check("hold2_inst", Inst, 32'h1111_0004);
      check("hold2_req", {31'd0, IMemReq}, 32'd0);
      seq(1'b0, 32'd0);
      check("unhold_inst", Inst, 32'h2002_0005);
      check("unhold_idpc4", IDPCPlus4, 32'hC);
      check("unhold_valid", {31'd0, InstValid}, 32'd1);
      check("unhold_addr", IMemAddr, 32'hC);

      // branch back by 2 words from IDPCPlus4=0x10
      seq(1'b1, 32'h1111_000C);
      check("pre_br_idpc4", IDPCPlus4, 32'h10);
      step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'd0, 1'b1, 32'hBAD0_0010);
      check("br_addr", IMemAddr, 32'h8);
      check("br_inst", Inst, 32'h0);
      check("br_valid", {31'd0, InstValid}, 32'd0);
      seq(1'b1, 32'h2222_0008);
      check("br_next_inst", Inst, 32'h2222_0008);
      check("br_next_valid", {31'd0, InstValid}, 32'd1);
      check("br_next_idpc4", IDPCPlus4, 32'hC);

      // move to 0x4000000C: 0xC + (0x10000000 << 2)
      step(1'b0, 1'b1, 1'b0, 32'h1000_0000, 26'd0, 1'b1, 32'hBAD0_000C);
      check("far_addr", IMemAddr, 32'h4000_000C);
      seq(1'b1, 32'h3333_000C);
      check("far_idpc4", IDPCPlus4, 32'h4000_0010);

      // jump while request outstanding -> DROP
      step(1'b0, 1'b0, 1'b1, 32'd0, 26'h10, 1'b0, 32'd0);
      check("drop_addr", IMemAddr, 32'h4000_0010);
      check("drop_req", {31'd0, IMemReq}, 32'd1);
      check("drop_valid", {31'd0, InstValid}, 32'd0);
      seq(1'b1, 32'hDEAD_BEEF);
      check("drop_done_addr", IMemAddr, 32'h4000_0040);
      check("drop_done_inst", Inst, 32'h0);
      check("drop_done_valid", {31'd0, InstValid}, 32'd0);
      seq(1'b1, 32'h4444_0040);
      check("jmp_inst", Inst, 32'h4444_0040);
      check("jmp_idpc4", IDPCPlus4, 32'h4000_0044);

      // second redirect in DROP overwrites the target
      step(1'b0, 1'b0, 1'b1, 32'd0, 26'h20, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd4, 26'd0, 1'b0, 32'd0);
      check("drop2_addr", IMemAddr, 32'h4000_0044);
      seq(1'b1, 32'hDEAD_BEEF);
      check("drop2_tgt", IMemAddr, 32'h4000_0054);

      // jump with stall is taken
      step(1'b1, 1'b0, 1'b1, 32'd0, 26'h3, 1'b1, 32'hBAD0_0054);
      check("jst_addr", IMemAddr, 32'h4000_000C);
      check("jst_valid", {31'd0, InstValid}, 32'd0);
      seq(1'b1, 32'h5555_000C);
      check("jst_idpc4", IDPCPlus4, 32'h4000_0010);

      // branch with stall is ignored
      step(1'b1, 1'b1, 1'b0, 32'd8, 26'd0, 1'b0, 32'd0);
      check("bst_addr", IMemAddr, 32'h4000_0010);
      check("bst_inst", Inst, 32'h5555_000C);
      check("bst_valid", {31'd0, InstValid}, 32'd1);

      // branch to 0xFFFFFFFC, then PC+4 wraps
      step(1'b0, 1'b1, 1'b0, 32'h2FFF_FFFB, 26'd0, 1'b0, 32'd0);
      seq(1'b1, 32'hDEAD_BEEF);
      check("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
      seq(1'b1, 32'h6666_FFFC);
      check("wrap_inst", Inst, 32'h6666_FFFC);
      check("wrap_idpc4", IDPCPlus4, 32'h0);
      check("wrap_next", IMemAddr, 32'h0);
      seq(1'b0, 32'd0);
      check("bubble_inst", Inst, 32'h0);
      check("bubble_valid", {31'd0, InstValid}, 32'd0);

      // reset pulse mid-request
      seq(1'b1, 32'h7777_0000);
      check("pre_rst_addr", IMemAddr, 32'h4);
      #2 ResetN = 1'b0;
      #1;
      check("mid_rst_req", {31'd0, IMemReq}, 32'd0);
      check("mid_rst_inst", Inst, 32'h0);
      check("mid_rst_idpc4", IDPCPlus4, 32'h0);
      seq(1'b0, 32'd0);
      ResetN = 1'b1;
      #1;
      check("post_rst_req0", {31'd0, IMemReq}, 32'd0);
      seq(1'b0, 32'd0);
      check("post_rst_req1", {31'd0, IMemReq}, 32'd1);
      check("post_rst_addr", IMemAddr, 32'h0);
      seq(1'b1, 32'h8888_0000);
      check("post_rst_inst", Inst, 32'h8888_0000);
      check("post_rst_idpc4", IDPCPlus4, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors",
               nchecks, nerrors);
      $finish;
   end

endmodule
